aesl_deadlock_monitor_param: RTL
================================

# aesl_deadlock_monitor_param

Parametrised dataflow deadlock monitor for the RTL co-simulation harness of the generated `myproject` design. It watches every dataflow process's idle and channel-block status, plus each AXI-Stream port's block status, and flags a deadlock when all processes are stopped and at least one is stalled on an AXI-Stream port. Relative to the fixed 14-process monitor, this block adds:
- parametrised process and port counts, with a configurable port-to-process mapping;
- a persistence (debounce) filter;
- a sticky flag and diagnostic snapshots captured at first detection.

## Interface
Parameters:
- `NUM_PROC`, 14, number of dataflow processes (≥1).
- `NUM_AXIS`, 2, number of AXI-Stream ports (≥1).
- `AXIS_OWNER`, {8'd13, 8'd0}, packed `NUM_AXIS*8` bits; byte i = index of the process owning port i (< `NUM_PROC`).
- `DEBOUNCE`, 1, consecutive cycles the stop condition must hold before `block` asserts (≥1).
- `CNT_W`, 32, width of cycle counters.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: clears sticky flag, snapshots and `block_cycle`.
- `axis_block_sigs` in `NUM_AXIS`: bit i = port i blocked.
- `inst_idle_sigs` in `NUM_PROC`: bit p = process p idle.
- `inst_block_sigs` in `NUM_PROC`: bit p = process p blocked on an internal channel.
- `block` out 1: live, debounced deadlock indication.
- `block_sticky` out 1: set at first detection, held until `clear`/`reset`.
- `block_proc_snapshot` out `NUM_PROC`: `axis_vec` captured at detection.
- `block_axis_snapshot` out `NUM_AXIS`: `axis_block_sigs` captured at detection.
- `block_cycle` out `CNT_W`: value of the free-running cycle counter at detection.
- `stall_cycles` out `CNT_W`: cycles spent with `block`=1 since reset/`clear`.

## Operation
- `axis_vec[p]` = OR of `axis_block_sigs[i]` over all i with `AXIS_OWNER[i]`==p; 0 if no port maps to p.
- `stop[p]` = `inst_idle_sigs[p]` | `inst_block_sigs[p]` | `axis_vec[p]`.
- `cond` = (|`axis_vec`) & (&`stop`). Evaluated combinationally from the current-cycle inputs.
- FSM:
  - RUN: if `cond`, load debounce count 1; go to PEND, or BLOCKED directly if `DEBOUNCE`==1.
  - PEND: if `cond`, increment count; at count==`DEBOUNCE`-1 with `cond`, go to BLOCKED. If `!cond`, go to RUN with count 0.
  - BLOCKED: `block`=1. If `!cond`, go to RUN (no hysteresis).
  - Debounce counter width is clog2(`DEBOUNCE`+1).
- Entry into BLOCKED is a detection event:
  - If `block_sticky`=0: set it, capture `block_proc_snapshot`, `block_axis_snapshot` and `block_cycle` from the same cycle's inputs/counter.
  - If already sticky: snapshots keep their first-detection values.
- Free-running cycle counter increments every cycle from 0 after reset and saturates at all-ones. `stall_cycles` increments every cycle `block`=1 and also saturates.
- `clear`: zeroes sticky, snapshots, `block_cycle`, `stall_cycles`. Does not change FSM state or the free-running counter.
- `clear` coincident with a detection event: detection wins. Sticky=1, snapshots recaptured, `stall_cycles` restarts at 0.

## Timing
- Reset: all outputs 0, FSM=RUN, all counters 0. `reset` overrides `clear` and `cond`.
- Reset asserted mid-PEND or mid-BLOCKED: the next cycle is RUN with all outputs 0.
- All outputs are registered.
- Latency: with `cond` true in cycles k..k+`DEBOUNCE`-1, `block`=1 from cycle k+`DEBOUNCE`. `block_sticky` and the snapshots update on the same edge.
- `DEBOUNCE`=1 gives one-cycle registered latency, identical to the legacy monitor.
- `cond` drops in cycle j: `block`=0 from cycle j+1.
- Any `!cond` cycle in PEND restarts the debounce from zero.
- `stall_cycles` counts the first BLOCKED cycle; it reads 1 one cycle after `block` rises.

## Test plan
- Defaults (`NUM_PROC`=14, `NUM_AXIS`=2, `DEBOUNCE`=1): all idle, `axis_block_sigs`=2'b01 from cycle 10 → `block`=1 from cycle 11; `block_proc_snapshot`=14'h0001, `block_axis_snapshot`=2'b01, `block_cycle`=10.
- All processes stopped but `axis_block_sigs`=0 for 100 cycles → `block`=0 and `block_sticky`=0 throughout.
- `DEBOUNCE`=4: `cond` held 3 cycles, dropped 1, then held 4 cycles starting at cycle 20 → no assertion on the first burst; `block`=1 from cycle 24.
- Deadlock for 5 cycles, release, deadlock again → `block` falls one cycle after release and rises again. Sticky stays 1; snapshots and `block_cycle` keep first-event values; `stall_cycles`=10 after the second episode's fifth cycle.
- `clear` pulsed the same cycle as a new detection → `block_sticky`=1 and snapshots equal the new event. `clear` alone → sticky, snapshots and `block_cycle` read 0 next cycle while `block` follows `cond`.
- `NUM_AXIS`=3, `AXIS_OWNER`={5,5,0}: only port 2 blocked, process 5 busy otherwise, rest idle → deadlock with `block_proc_snapshot` bit 5 set. `reset` pulsed during BLOCKED → all outputs 0 the next cycle.

Source files
------------

// File: rtl/aesl_deadlock_monitor_param_if.sv
// Signal bundle for aesl_deadlock_monitor_param.
// Purpose : groups the harness-side status inputs and the monitor's deadlock
//           indication and diagnostic outputs into one connection.
// Signals : clear                 - clears sticky flag, snapshots and counters
//           axis_block_sigs       - per AXI-Stream port blocked flag
//           inst_idle_sigs        - per process idle flag
//           inst_block_sigs       - per process internal-channel blocked flag
//           block                 - live, debounced deadlock indication
//           block_sticky          - set on first detection, held until clear
//           block_proc_snapshot   - per-process AXI-Stream block vector at detection
//           block_axis_snapshot   - axis_block_sigs at detection
//           block_cycle           - free-running cycle count at detection
//           stall_cycles          - cycles spent with block=1
// Modports: master drives the status inputs (harness / bench),
//           slave is the monitor.
interface aesl_deadlock_monitor_param_if #(
  parameter int NUM_PROC = 14,
  parameter int NUM_AXIS = 2,
  parameter int CNT_W    = 32
);
  logic                clear;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_PROC-1:0] inst_idle_sigs;
  logic [NUM_PROC-1:0] inst_block_sigs;
  logic                block;
  logic                block_sticky;
  logic [NUM_PROC-1:0] block_proc_snapshot;
  logic [NUM_AXIS-1:0] block_axis_snapshot;
  logic [CNT_W-1:0]    block_cycle;
  logic [CNT_W-1:0]    stall_cycles;

  modport master (
    output clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    input  block, block_sticky, block_proc_snapshot, block_axis_snapshot,
           block_cycle, stall_cycles
  );

  modport slave (
    input  clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    output block, block_sticky, block_proc_snapshot, block_axis_snapshot,
           block_cycle, stall_cycles
  );
endinterface

// File: rtl/aesl_deadlock_monitor_param.sv
// Parametrised dataflow deadlock monitor.
// Purpose : flags a deadlock when every dataflow process is stopped (idle,
//           blocked on an internal channel, or blocked on an AXI-Stream port)
//           and at least one is stalled on an AXI-Stream port. The stop
//           condition is debounced over DEBOUNCE cycles. The first detection
//           is latched with a snapshot of which processes/ports were blocked
//           and the cycle number it happened in.
// Ports   : clock - rising-edge clock
//           reset - synchronous, active-high
//           mon   - status inputs / monitor outputs (slave modport)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | stop condition not present
// ST_PEND    | stop condition present, debounce count still running
// ST_BLOCKED | stop condition held long enough; block asserted
module aesl_deadlock_monitor_param #(
  parameter int                      NUM_PROC   = 14,
  parameter int                      NUM_AXIS   = 2,
  parameter logic [NUM_AXIS*8-1:0]   AXIS_OWNER = {8'd13, 8'd0},
  parameter int                      DEBOUNCE   = 1,
  parameter int                      CNT_W      = 32
) (
  input logic                           clock,
  input logic                           reset,
  aesl_deadlock_monitor_param_if.slave  mon
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PEND    = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DB_W-1:0]     db_cnt, db_cnt_nxt;

  logic [NUM_PROC-1:0] axis_vec;
  logic [NUM_PROC-1:0] stop;
  logic                cond;
  logic                detect;

  logic                block_q;
  logic                sticky_q;
  logic [NUM_PROC-1:0] proc_snap_q;
  logic [NUM_AXIS-1:0] axis_snap_q;
  logic [CNT_W-1:0]    block_cycle_q;
  logic [CNT_W-1:0]    stall_q;
  logic [CNT_W-1:0]    cycle_cnt;

  // Fold each AXI-Stream port's block flag onto the process that owns it.
  always_comb begin
    axis_vec = '0;
    for (int p = 0; p < NUM_PROC; p++) begin
      for (int i = 0; i < NUM_AXIS; i++) begin
        if (AXIS_OWNER[i*8 +: 8] == 8'(p))
          axis_vec[p] = axis_vec[p] | mon.axis_block_sigs[i];
      end
    end
  end

  assign stop = mon.inst_idle_sigs | mon.inst_block_sigs | axis_vec;
  assign cond = (|axis_vec) & (&stop);

  // db_cnt counts cond cycles already seen while in ST_PEND; the cycle that
  // brings it to DEBOUNCE-1 with cond still true is the last debounce cycle.
  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    unique case (state)
      ST_RUN: begin
        if (cond) begin
          if (DEBOUNCE == 1) begin
            state_nxt  = ST_BLOCKED;
            db_cnt_nxt = '0;
          end else begin
            state_nxt  = ST_PEND;
            db_cnt_nxt = DB_W'(1);
          end
        end
      end
      ST_PEND: begin
        if (!cond) begin
          state_nxt  = ST_RUN;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
          state_nxt  = ST_BLOCKED;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      ST_BLOCKED: begin
        if (!cond) begin
          state_nxt  = ST_RUN;
          db_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt  = ST_RUN;
        db_cnt_nxt = '0;
      end
    endcase
  end

  assign detect = (state_nxt == ST_BLOCKED) && (state != ST_BLOCKED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_RUN;
      db_cnt  <= '0;
      block_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      db_cnt  <= db_cnt_nxt;
      block_q <= (state_nxt == ST_BLOCKED);
    end
  end

  // A detection that coincides with clear recaptures, so the sticky flag is
  // never left clear while a fresh episode has just begun.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt     <= '0;
      sticky_q      <= 1'b0;
      proc_snap_q   <= '0;
      axis_snap_q   <= '0;
      block_cycle_q <= '0;
      stall_q       <= '0;
    end else begin
      if (cycle_cnt != {CNT_W{1'b1}})
        cycle_cnt <= cycle_cnt + CNT_W'(1);

      if (detect && (!sticky_q || mon.clear)) begin
        sticky_q      <= 1'b1;
        proc_snap_q   <= axis_vec;
        axis_snap_q   <= mon.axis_block_sigs;
        block_cycle_q <= cycle_cnt;
      end else if (mon.clear) begin
        sticky_q      <= 1'b0;
        proc_snap_q   <= '0;
        axis_snap_q   <= '0;
        block_cycle_q <= '0;
      end

      if (mon.clear)
        stall_q <= '0;
      else if (block_q && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign mon.block               = block_q;
  assign mon.block_sticky        = sticky_q;
  assign mon.block_proc_snapshot = proc_snap_q;
  assign mon.block_axis_snapshot = axis_snap_q;
  assign mon.block_cycle         = block_cycle_q;
  assign mon.stall_cycles        = stall_q;

endmodule
